// File: rtl/seg7_scan_decoder_if.sv
// Display-side lines in and decoded frame out of the scan decoder, bundled
// so that the decoder and its driver connect through one port.
interface seg7_scan_decoder_if;
    logic [6:0]  i_seg;
    logic        i_dp;
    logic [3:0]  i_dig;
    logic [15:0] o_val;
    logic [3:0]  o_dp;
    logic        o_valid;
    logic        o_err;

    modport master (
        output i_seg, i_dp, i_dig,
        input  o_val, o_dp, o_valid, o_err
    );

    modport slave (
        input  i_seg, i_dp, i_dig,
        output o_val, o_dp, o_valid, o_err
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit hex frame from a multiplexed 7-segment display by
// accepting each digit after STABLE identical synchronized samples.
module seg7_scan_decoder #(
    parameter int unsigned STABLE = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    seg7_scan_decoder_if.slave bus
);
    typedef enum logic [1:0] {EXP0, EXP1, EXP2, EXP3} state_t;

    localparam logic [7:0] C_STABLE = 8'(STABLE);

    logic [11:0] r_sync1, r_sync2, r_prev;
    logic [7:0]  r_cnt;
    logic        r_accept;
    state_t      r_state;
    logic [3:0]  r_slot_val [3];
    logic [2:0]  r_slot_dp;
    logic [15:0] r_val;
    logic [3:0]  r_dp;
    logic        r_valid, r_err;

    state_t      w_state_next;
    logic [7:0]  w_cnt_next;
    logic [3:0]  w_dig;
    logic [6:0]  w_seg;
    logic        w_dp;
    logic        w_onehot, w_expected, w_dec_ok;
    logic [3:0]  w_nibble;
    logic        w_store, w_valid_next, w_err_next;

    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;
            7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;
            7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign w_cnt_next = (r_sync2 != r_prev)  ? 8'd1 :
                        (r_cnt == C_STABLE)  ? r_cnt : r_cnt + 8'd1;

    // During the acceptance cycle r_prev holds the sample that completed its run
    assign w_dig      = r_prev[11:8];
    assign w_dp       = r_prev[7];
    assign w_seg      = r_prev[6:0];
    assign w_onehot   = (w_dig != 4'd0) && ((w_dig & (w_dig - 4'd1)) == 4'd0);
    assign w_expected = (w_dig == (4'b0001 << r_state));
    assign {w_dec_ok, w_nibble} = decode(w_seg);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state_next = r_state;
        w_store      = 1'b0;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        if (r_accept && w_onehot) begin
            if (w_expected) begin
                if (!w_dec_ok) begin
                    w_err_next   = 1'b1;
                    w_state_next = EXP0;
                end else if (r_state == EXP3) begin
                    w_valid_next = 1'b1;
                    w_state_next = EXP0;
                end else begin
                    w_store      = 1'b1;
                    w_state_next = state_t'(r_state + 2'd1);
                end
            end else if (r_state != EXP0) begin
                w_err_next   = 1'b1;
                w_state_next = EXP0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_reset) r_state <= EXP0;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_prev    <= '0;
            r_cnt     <= 8'd1;
            r_accept  <= 1'b0;
            // NOTE: shadow slots are reset too, even though every frame overwrites them before use.
            for (int i = 0; i < 3; i++) r_slot_val[i] <= 4'h0;
            r_slot_dp <= '0;
            r_val     <= 16'h0000;
            r_dp      <= 4'h0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_sync1  <= {bus.i_dig, bus.i_dp, bus.i_seg};
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_cnt    <= w_cnt_next;
            r_accept <= (w_cnt_next == C_STABLE) && (r_cnt != C_STABLE);
            for (int i = 0; i < 3; i++) begin
                if (w_store && (r_state == state_t'(i))) begin
                    r_slot_val[i] <= w_nibble;
                    r_slot_dp[i]  <= w_dp;
                end
            end
            if (w_valid_next) begin
                r_val <= {w_nibble, r_slot_val[2], r_slot_val[1], r_slot_val[0]};
                r_dp  <= {w_dp, r_slot_dp};
            end
            r_valid <= w_valid_next;
            r_err   <= w_err_next;
        end
    end

    assign bus.o_val   = r_val;
    assign bus.o_dp    = r_dp;
    assign bus.o_valid = r_valid;
    assign bus.o_err   = r_err;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scans digit patterns onto the display
// lines and checks frames, error pulses and latency against hand-computed values.
module tb_seg7_scan_decoder;
    localparam int LAT = 7;  // 2 sync + STABLE(4) + 1

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_valid = 0;
    int   n_err = 0;
    int   n_both = 0;
    int   valid_cyc = 0;
    int   err_cyc = 0;
    int   set_cyc [4];
    int   v0, e0;

    seg7_scan_decoder_if bus ();

    seg7_scan_decoder #(.STABLE(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge
    always @(negedge clk) begin
        if (bus.o_valid) begin
            n_valid   = n_valid + 1;
            valid_cyc = cyc;
        end
        if (bus.o_err) begin
            n_err   = n_err + 1;
            err_cyc = cyc;
        end
        if (bus.o_valid && bus.o_err) n_both = n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic blank(input int k);
        bus.i_dig = 4'h0;
        bus.i_seg = 7'h00;
        bus.i_dp  = 1'b0;
        repeat (k) step();
    endtask

    task automatic show(input int n, input logic [6:0] seg, input logic dp, input int hold);
        bus.i_dig  = 4'(1 << n);
        bus.i_seg  = seg;
        bus.i_dp   = dp;
        set_cyc[n] = cyc;
        repeat (hold) step();
        blank(2);
    endtask

    task automatic snap();
        v0 = n_valid;
        e0 = n_err;
    endtask

    initial begin
        bus.i_dig = 4'h0;
        bus.i_seg = 7'h00;
        bus.i_dp  = 1'b0;
        repeat (3) step();
        check("rst_val",   32'(bus.o_val),   32'h0);
        check("rst_dp",    32'(bus.o_dp),    32'h0);
        check("rst_valid", 32'(bus.o_valid), 32'h0);
        check("rst_err",   32'(bus.o_err),   32'h0);
        rst = 1'b0;
        blank(4);

        // Basic frame 3,2,1,8 with dp on digit 2
        snap();
        show(0, 7'h4F, 1'b0, 8);
        show(1, 7'h5B, 1'b0, 8);
        show(2, 7'h06, 1'b1, 8);
        show(3, 7'h7F, 1'b0, 8);
        blank(4);
        check("a_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("a_err_cnt",   32'(n_err - e0),   32'd0);
        check("a_val",       32'(bus.o_val),    32'h8123);
        check("a_dp",        32'(bus.o_dp),     32'h4);
        check("a_latency",   32'(valid_cyc - set_cyc[3]), 32'(LAT));

        // Invalid pattern on digit 1
        snap();
        show(0, 7'h4F, 1'b0, 8);
        show(1, 7'h55, 1'b0, 8);
        show(2, 7'h06, 1'b1, 8);
        show(3, 7'h7F, 1'b0, 8);
        blank(4);
        check("b_err_cnt",   32'(n_err - e0),   32'd1);
        check("b_valid_cnt", 32'(n_valid - v0), 32'd0);
        check("b_val_kept",  32'(bus.o_val),    32'h8123);
        check("b_err_lat",   32'(err_cyc - set_cyc[1]), 32'(LAT));

        // Skipped digit 2, then a clean A,B,C,D frame
        snap();
        show(0, 7'h3F, 1'b0, 8);
        show(1, 7'h06, 1'b0, 8);
        show(3, 7'h4F, 1'b0, 8);
        blank(4);
        check("c_err_cnt",   32'(n_err - e0),   32'd1);
        check("c_err_lat",   32'(err_cyc - set_cyc[3]), 32'(LAT));
        snap();
        show(0, 7'h77, 1'b0, 8);
        show(1, 7'h7C, 1'b0, 8);
        show(2, 7'h39, 1'b0, 8);
        show(3, 7'h5E, 1'b0, 8);
        blank(4);
        check("c_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("c_val",       32'(bus.o_val),    32'hDCBA);
        check("c_dp",        32'(bus.o_dp),     32'h0);

        // Too-short holds and a toggling segment bus never accept
        snap();
        show(0, 7'h3F, 1'b0, 3);
        show(1, 7'h06, 1'b0, 3);
        show(2, 7'h5B, 1'b0, 3);
        show(3, 7'h4F, 1'b0, 3);
        bus.i_dig = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            bus.i_seg = (i % 2 == 0) ? 7'h3F : 7'h06;
            repeat (2) step();
        end
        blank(6);
        check("d_valid_cnt", 32'(n_valid - v0), 32'd0);
        check("d_err_cnt",   32'(n_err - e0),   32'd0);
        check("d_val_kept",  32'(bus.o_val),    32'hDCBA);

        // Scan joined mid-frame at digit 2
        snap();
        show(2, 7'h5B, 1'b0, 8);
        show(3, 7'h4F, 1'b0, 8);
        check("e_no_early",  32'(n_valid - v0 + n_err - e0), 32'd0);
        show(0, 7'h6D, 1'b0, 8);
        show(1, 7'h7D, 1'b0, 8);
        show(2, 7'h07, 1'b0, 8);
        show(3, 7'h6F, 1'b1, 8);
        check("e_first_val", 32'(bus.o_val), 32'h9765);
        check("e_first_dp",  32'(bus.o_dp),  32'h8);
        show(0, 7'h3F, 1'b0, 8);
        show(1, 7'h06, 1'b0, 8);
        show(2, 7'h5B, 1'b0, 8);
        show(3, 7'h4F, 1'b0, 8);
        blank(4);
        check("e_valid_cnt", 32'(n_valid - v0), 32'd2);
        check("e_val2",      32'(bus.o_val),    32'h3210);

        // Reset pulse while waiting for digit 2
        show(0, 7'h66, 1'b1, 8);
        show(1, 7'h71, 1'b0, 8);
        bus.i_dig = 4'b0100;
        bus.i_seg = 7'h79;
        repeat (3) step();
        rst = 1'b1;
        step();
        check("f_rst_val", 32'(bus.o_val), 32'h0);
        check("f_rst_dp",  32'(bus.o_dp),  32'h0);
        rst = 1'b0;
        snap();
        repeat (8) step();
        blank(2);
        show(3, 7'h06, 1'b0, 8);
        blank(4);
        check("f_no_valid", 32'(n_valid - v0), 32'd0);
        check("f_no_err",   32'(n_err - e0),   32'd0);
        show(0, 7'h66, 1'b1, 8);
        show(1, 7'h71, 1'b0, 8);
        show(2, 7'h79, 1'b0, 8);
        show(3, 7'h06, 1'b0, 8);
        blank(4);
        check("f_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("f_val",       32'(bus.o_val),    32'h1EF4);
        check("f_dp",        32'(bus.o_dp),     32'h1);

        check("never_both", 32'(n_both), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE, default 4, number of consecutive identical synchronized samples required to accept a digit; legal range 2..255.
REQ-002 i_clk  input  1  system clock; all logic on rising edge.
REQ-003 i_reset  input  1  synchronous active-high reset.
REQ-004 i_seg  input  7  segment lines, active-high; bit0=a, bit1=b ... bit6=g; asynchronous to i_clk.
REQ-005 i_dp  input  1  decimal-point line, active-high; asynchronous.
REQ-006 i_dig  input  4  digit enables, active-high; bit0 = rightmost digit; asynchronous.
REQ-007 o_val  output  16  last complete frame; o_val[3:0] = digit 0 ... o_val[15:12] = digit 3.
REQ-008 o_dp  output  4  decimal points of last complete frame, bit n = digit n.
REQ-009 o_valid  output  1  one-cycle pulse when o_val/o_dp update.
REQ-010 o_err  output  1  one-cycle pulse on frame abort.

Function
REQ-011 i_seg, i_dp and i_dig shall each pass through a 2-flop synchronizer; "sample" means the 12-bit second-stage value.
REQ-012 Stability counter shall reset to 1 when the current sample differs from the previous sample, else increment, saturating at STABLE.
REQ-013 A digit shall be "accepted" on the single cycle the counter transitions to STABLE with sample i_dig exactly one-hot; at most one acceptance per stable period.
REQ-014 Sample i_dig zero or multi-hot shall be treated as blanking: no acceptance, no error, frame state unchanged.
REQ-015 Decode table (gfedcba hex -> nibble): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F.
REQ-016 Any other segment pattern at acceptance, including 00, shall be invalid.
REQ-017 Frame FSM states: EXP0, EXP1, EXP2, EXP3; EXPn expects acceptance with i_dig bit n set.
REQ-018 In EXPn, valid acceptance of digit n shall store nibble and dp in shadow slot n and advance to EXP(n+1); n=3 instead returns to EXP0.
REQ-019 On acceptance of digit 3 in EXP3, o_val/o_dp shall load all four shadow slots (slot 3 from the current decode) on the next rising edge, o_valid high for exactly that one cycle.
REQ-020 In EXPn with n>0, acceptance of wrong digit, or invalid pattern in any state, shall pulse o_err one cycle after acceptance and return to EXP0; o_val/o_dp unchanged.
REQ-021 In EXP0, acceptance of a digit other than 0 shall be ignored silently (resynchronization to scan), no o_err.
REQ-022 Latency: input change to o_valid = 2 (sync) + STABLE + 1 cycles for the final digit.
REQ-023 o_valid and o_err shall never assert in the same cycle.
REQ-024 Shadow slots shall not be cleared on abort; they are overwritten before next use.

Reset
REQ-025 While i_reset is high: synchronizer flops, sample history and shadow slots = 0, counter = 1, FSM = EXP0, o_val = 16'h0000, o_dp = 4'h0, o_valid = 0, o_err = 0.
REQ-026 Reset asserted mid-frame shall discard the partial frame; first acceptance after release needs a full STABLE run of fresh samples.

Verification
REQ-027 STABLE=4; scan digits 0..3 with patterns 4F,5B,06,7F, dp on digit 2, each held 8 cycles, 2 blank cycles between -> single o_valid, o_val=16'h8123, o_dp=4'b0100.
REQ-028 Same scan but digit 1 pattern 0x55 -> o_err pulse one cycle after digit 1 acceptance, no o_valid, o_val keeps prior value.
REQ-029 Scan 0,1,3 (skip 2) -> o_err on digit 3 acceptance; following correct 0..3 scan of 77,7C,39,5E -> o_valid, o_val=16'hDCBA.
REQ-030 Digit held only 3 cycles (STABLE=4), or i_seg toggling every 2 cycles -> no acceptance, no o_valid, no o_err.
REQ-031 Start scan at digit 2, then continuous 0..3 cycle -> digits 2,3 ignored silently; first o_valid after the first complete 0..3.
REQ-032 Assert i_reset during EXP2 for 1 cycle -> outputs 0 next cycle; resumed scan at digit 2 produces no o_valid until a full 0..3 frame.
